// File: rtl/prog_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : prog_loader_if                                                |
// | Purpose  : Image stream, RAM write port and CPU control bundle for       |
// |            prog_loader.                                                  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface prog_loader_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] len;
    logic              abort;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_sel;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              cpu_rst;
    logic              cpu_halt;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       run_cycles;

    modport master (
        input  start, len, abort, in_valid, in_data, cpu_halt,
        output in_ready, mem_sel, mem_wr, mem_addr, mem_data, cpu_rst,
               busy, done, err, run_cycles
    );

    modport slave (
        output start, len, abort, in_valid, in_data, cpu_halt,
        input  in_ready, mem_sel, mem_wr, mem_addr, mem_data, cpu_rst,
               busy, done, err, run_cycles
    );
endinterface
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : prog_loader                                                   |
// | Purpose  : Streams a program image into RAM, releases the CPU and        |
// |            supervises the run until halt or timeout.                     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module prog_loader #(
    parameter int                ADDR_W    = 13,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] LOAD_BASE = '0,
    parameter logic [15:0]       TIMEOUT   = 16'hFFFF
) (
    input  wire logic     clk,
    input  wire logic     rst,
    prog_loader_if.master bus
);

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_load   = 3'd1;
    localparam logic [2:0] c_drain  = 3'd2;
    localparam logic [2:0] c_run    = 3'd3;
    localparam logic [2:0] c_halted = 3'd4;

    localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [15:0]       c_run_max  = 16'hFFFF;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_remaining;
    logic              r_mem_sel;
    logic              r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_cpu_rst;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [15:0]       r_run_cycles;
    logic              r_run_first;

    logic              w_active;
    logic              w_accept;
    logic [15:0]       w_run_next;
    logic              w_timeout;

    assign w_active   = (r_state == c_load) || (r_state == c_drain) || (r_state == c_run);
    assign w_accept   = (r_state == c_load) && bus.in_valid && !bus.abort;
    assign w_run_next = (r_run_cycles == c_run_max) ? r_run_cycles : r_run_cycles + 16'd1;
    assign w_timeout  = (w_run_next >= TIMEOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_idle;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_mem_sel    <= 1'b1;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_cpu_rst    <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_run_cycles <= '0;
            r_run_first  <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse per accepted byte.
            r_mem_wr <= 1'b0;
            if (w_active && bus.abort) begin
                r_state     <= c_idle;
                r_err       <= 1'b1;
                r_cpu_rst   <= 1'b1;
                r_mem_sel   <= 1'b1;
                r_busy      <= 1'b0;
                r_done      <= 1'b0;
                r_run_first <= 1'b0;
            end else begin
                case (r_state)
                    c_idle, c_halted: begin
                        if (bus.start) begin
                            if (bus.len != '0) begin
                                r_state     <= c_load;
                                r_err       <= 1'b0;
                                r_addr      <= LOAD_BASE;
                                r_remaining <= bus.len;
                                r_cpu_rst   <= 1'b1;
                                r_mem_sel   <= 1'b1;
                                r_busy      <= 1'b1;
                                r_done      <= 1'b0;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    c_load: begin
                        if (w_accept) begin
                            r_mem_wr    <= 1'b1;
                            r_mem_addr  <= r_addr;
                            r_mem_data  <= bus.in_data;
                            r_addr      <= r_addr + c_addr_one;
                            r_remaining <= r_remaining - c_addr_one;
                            if (r_remaining == c_addr_one) begin
                                r_state <= c_drain;
                            end
                        end
                    end
                    c_drain: begin
                        r_state      <= c_run;
                        r_mem_sel    <= 1'b0;
                        r_cpu_rst    <= 1'b0;
                        r_run_cycles <= '0;
                        r_run_first  <= 1'b1;
                    end
                    c_run: begin
                        r_run_first  <= 1'b0;
                        r_run_cycles <= w_run_next;
                        // Halt outranks a coincident timeout; the first cycle's halt is stale.
                        if (bus.cpu_halt && !r_run_first) begin
                            r_state <= c_halted;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (w_timeout) begin
                            r_state   <= c_halted;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_err     <= 1'b1;
                            r_cpu_rst <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= c_idle;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready   = (r_state == c_load) && !bus.abort;
    assign bus.mem_sel    = r_mem_sel;
    assign bus.mem_wr     = r_mem_wr;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_data   = r_mem_data;
    assign bus.cpu_rst    = r_cpu_rst;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.run_cycles = r_run_cycles;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_prog_loader                                                |
// | Purpose  : Self-checking bench for prog_loader (two load bases).         |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_prog_loader;

    localparam int c_timeout = 20;
    localparam int c_base1   = 'h1FFE;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [12:0] len;
    logic        abort;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        cpu_halt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  exp_bytes[$];
    logic [20:0] wq0[$];
    logic [20:0] wq1[$];

    prog_loader_if #(.ADDR_W(13), .DATA_W(8)) bus0 ();
    prog_loader_if #(.ADDR_W(13), .DATA_W(8)) bus1 ();

    assign bus0.start = start;    assign bus1.start = start;
    assign bus0.len = len;        assign bus1.len = len;
    assign bus0.abort = abort;    assign bus1.abort = abort;
    assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;
    assign bus0.in_data = in_data;    assign bus1.in_data = in_data;
    assign bus0.cpu_halt = cpu_halt;  assign bus1.cpu_halt = cpu_halt;

    prog_loader #(.ADDR_W(13), .DATA_W(8), .LOAD_BASE(13'h0000), .TIMEOUT(16'd20)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    prog_loader #(.ADDR_W(13), .DATA_W(8), .LOAD_BASE(13'h1FFE), .TIMEOUT(16'd20)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    // Record every RAM write mid-cycle.
    always @(negedge clk) begin
        if (bus0.mem_wr === 1'b1) wq0.push_back({bus0.mem_addr, bus0.mem_data});
        if (bus1.mem_wr === 1'b1) wq1.push_back({bus1.mem_addr, bus1.mem_data});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".mem_sel"},    bus0.mem_sel, 1);
        chk({tag, ".cpu_rst"},    bus0.cpu_rst, 1);
        chk({tag, ".mem_wr"},     bus0.mem_wr, 0);
        chk({tag, ".mem_addr"},   bus0.mem_addr, 0);
        chk({tag, ".mem_data"},   bus0.mem_data, 0);
        chk({tag, ".busy"},       bus0.busy, 0);
        chk({tag, ".done"},       bus0.done, 0);
        chk({tag, ".err"},        bus0.err, 0);
        chk({tag, ".run_cycles"}, bus0.run_cycles, 0);
        chk({tag, ".in_ready"},   bus0.in_ready, 0);
        chk({tag, ".mem_addr1"},  bus1.mem_addr, 0);
        chk({tag, ".cpu_rst1"},   bus1.cpu_rst, 1);
    endtask

    task automatic do_start(input int n);
        wq0.delete();
        wq1.delete();
        start = 1'b1;
        len   = n[12:0];
        step();
        start = 1'b0;
        len   = '0;
    endtask

    // Presents n random bytes; in_valid follows pat (LSB first) when pat_len>0, else random gaps.
    task automatic feed(input int n, input int gap_pct, input logic [31:0] pat, input int pat_len,
                        input string tag);
        int   idx;
        int   cyc;
        logic acc;
        exp_bytes.delete();
        for (int i = 0; i < n; i++) exp_bytes.push_back(8'($urandom));
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 400) begin
            if (pat_len > 0) in_valid = pat[cyc % pat_len];
            else             in_valid = ($urandom_range(0, 99) >= gap_pct);
            in_data = in_valid ? exp_bytes[idx] : 8'($urandom);
            #1;
            acc = in_valid && (bus0.in_ready === 1'b1);
            step();
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, ".accepted"}, idx, n);
    endtask

    task automatic wait_run(input string tag);
        int g;
        g = 0;
        while (!(bus0.busy === 1'b1 && bus0.cpu_rst === 1'b0) && g < 10) begin
            step();
            g++;
        end
        chk({tag, ".reach_run"}, (g < 10), 1);
    endtask

    // Reference: byte i lands at (base + i) mod 8192, once, in order.
    task automatic check_writes(input string tag);
        logic [20:0] e0;
        logic [20:0] e1;
        chk({tag, ".nwr0"}, wq0.size(), exp_bytes.size());
        chk({tag, ".nwr1"}, wq1.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size(); i++) begin
            e0 = {13'(i % 8192), exp_bytes[i]};
            e1 = {13'((c_base1 + i) % 8192), exp_bytes[i]};
            if (i < wq0.size()) chk($sformatf("%s.wr0[%0d]", tag, i), wq0[i], e0);
            if (i < wq1.size()) chk($sformatf("%s.wr1[%0d]", tag, i), wq1[i], e1);
        end
    endtask

    // Called in the first RUN cycle; halt is held high from RUN cycle halt_from (<0: never).
    task automatic run_check(input int halt_from, input string tag);
        int   idx;
        int   eff;
        int   exp_rc;
        logic exp_err;
        if (halt_from < 0)      eff = -1;
        else if (halt_from < 1) eff = 1;
        else                    eff = halt_from;
        if (eff >= 0 && eff + 1 <= c_timeout) begin
            exp_rc  = eff + 1;
            exp_err = 1'b0;
        end else begin
            exp_rc  = c_timeout;
            exp_err = 1'b1;
        end
        idx = 0;
        while (bus0.done !== 1'b1 && idx < 200) begin
            cpu_halt = (halt_from >= 0) && (idx >= halt_from);
            step();
            idx++;
        end
        cpu_halt = 1'b0;
        chk({tag, ".run_len"},     idx, exp_rc);
        chk({tag, ".run_cycles"},  bus0.run_cycles, exp_rc);
        chk({tag, ".run_cycles1"}, bus1.run_cycles, exp_rc);
        chk({tag, ".done"},        bus0.done, 1);
        chk({tag, ".busy"},        bus0.busy, 0);
        chk({tag, ".err"},         bus0.err, exp_err);
        chk({tag, ".cpu_rst"},     bus0.cpu_rst, exp_err);
        chk({tag, ".mem_sel"},     bus0.mem_sel, 0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        len      = '0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        cpu_halt = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        step();
        rst = 1'b0;
        step();

        // Back-to-back three-byte load, cycle by cycle.
        do_start(3);
        chk("t1.busy_load", bus0.busy, 1);
        chk("t1.in_ready",  bus0.in_ready, 1);
        in_valid = 1'b1;
        in_data  = 8'hA1;
        step();
        chk("t1.wr0", {bus0.mem_wr, bus0.mem_addr, bus0.mem_data}, {1'b1, 13'h0000, 8'hA1});
        chk("t1.wr0b", {bus1.mem_wr, bus1.mem_addr}, {1'b1, 13'h1FFE});
        in_data = 8'hB2;
        step();
        chk("t1.wr1", {bus0.mem_wr, bus0.mem_addr, bus0.mem_data}, {1'b1, 13'h0001, 8'hB2});
        chk("t1.wr1b", {bus1.mem_wr, bus1.mem_addr}, {1'b1, 13'h1FFF});
        in_data = 8'hC3;
        step();
        in_valid = 1'b0;
        chk("t1.wr2", {bus0.mem_wr, bus0.mem_addr, bus0.mem_data}, {1'b1, 13'h0002, 8'hC3});
        chk("t1.wr2b", {bus1.mem_wr, bus1.mem_addr}, {1'b1, 13'h0000});
        chk("t1.cpu_rst_drain", bus0.cpu_rst, 1);
        chk("t1.busy_drain", bus0.busy, 1);
        step();
        chk("t1.cpu_rst_run", bus0.cpu_rst, 0);
        chk("t1.mem_wr_run",  bus0.mem_wr, 0);
        chk("t1.mem_sel_run", bus0.mem_sel, 0);
        chk("t1.busy_run",    bus0.busy, 1);
        chk("t1.rc_entry",    bus0.run_cycles, 0);

        // Halt during the tenth RUN cycle.
        run_check(9, "t4");
        start = 1'b1;
        len   = '0;
        step();
        start = 1'b0;
        chk("t4.len0_err",  bus0.err, 1);
        chk("t4.len0_done", bus0.done, 1);
        chk("t4.len0_busy", bus0.busy, 0);
        chk("t4.len0_rst",  bus0.cpu_rst, 0);
        chk("t4.len0_rc",   bus0.run_cycles, 10);

        // Gapped stream from HALTED; dut1 wraps 1FFF -> 0000.
        do_start(4);
        chk("t2.err_clr", bus0.err, 0);
        chk("t2.cpu_rst", bus0.cpu_rst, 1);
        chk("t2.mem_sel", bus0.mem_sel, 1);
        chk("t2.done",    bus0.done, 0);
        feed(4, 0, 32'b1011001, 7, "t2");
        wait_run("t2");
        check_writes("t2");
        run_check(0, "t2_first_halt_ignored");

        // start with len=0 is ignored while loading.
        do_start(3);
        start = 1'b1;
        len   = '0;
        step();
        start = 1'b0;
        chk("ign.err",  bus0.err, 0);
        chk("ign.busy", bus0.busy, 1);
        feed(3, 40, 0, 0, "ign");
        wait_run("ign");
        check_writes("ign");
        run_check(-1, "t5_timeout");

        // Halt coincides with timeout.
        do_start(2);
        feed(2, 20, 0, 0, "tie");
        wait_run("tie");
        check_writes("tie");
        run_check(c_timeout - 1, "tie");

        // Abort with a byte on offer.
        do_start(5);
        feed(2, 30, 0, 0, "t6");
        in_valid = 1'b1;
        in_data  = 8'h5A;
        abort    = 1'b1;
        #1;
        chk("t6.in_ready", bus0.in_ready, 0);
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("t6.busy",    bus0.busy, 0);
        chk("t6.err",     bus0.err, 1);
        chk("t6.cpu_rst", bus0.cpu_rst, 1);
        chk("t6.mem_sel", bus0.mem_sel, 1);
        step();
        check_writes("t6");

        // Abort in DRAIN still completes the last write.
        do_start(1);
        feed(1, 0, 0, 0, "drn");
        chk("drn.mem_wr", bus0.mem_wr, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("drn.busy", bus0.busy, 0);
        chk("drn.err",  bus0.err, 1);
        step();
        check_writes("drn");

        // Abort in RUN.
        do_start(2);
        feed(2, 10, 0, 0, "arun");
        wait_run("arun");
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("arun.busy",    bus0.busy, 0);
        chk("arun.err",     bus0.err, 1);
        chk("arun.cpu_rst", bus0.cpu_rst, 1);
        chk("arun.mem_sel", bus0.mem_sel, 1);
        chk("arun.done",    bus0.done, 0);

        // start and abort together in IDLE: start acts.
        wq0.delete();
        wq1.delete();
        start = 1'b1;
        len   = 13'd3;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("sa.busy", bus0.busy, 1);
        chk("sa.err",  bus0.err, 0);
        feed(3, 30, 0, 0, "sa");
        wait_run("sa");
        check_writes("sa");
        run_check(int'($urandom_range(1, 18)), "sa");

        // Random loads and halt points.
        for (int k = 0; k < 6; k++) begin
            int n;
            n = int'($urandom_range(1, 12));
            do_start(n);
            feed(n, int'($urandom_range(0, 60)), 0, 0, $sformatf("rnd%0d", k));
            wait_run($sformatf("rnd%0d", k));
            check_writes($sformatf("rnd%0d", k));
            run_check(int'($urandom_range(1, 18)), $sformatf("rnd%0d", k));
        end

        // Asynchronous reset in the middle of a run.
        do_start(2);
        feed(2, 0, 0, 0, "arst");
        wait_run("arst");
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check_reset("arst");
        step();
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
